// File: rtl/hsv_pwm_pkg.sv
// Shared types for the HSV colour-wheel sequencer: channel roles per phase and the phase/role lookup.
// Pure declarations; no state, no flow control.
package hsv_pwm_pkg;

    typedef enum logic [1:0] {
        ROLE_LOW  = 2'd0,
        ROLE_HIGH = 2'd1,
        ROLE_RISE = 2'd2,
        ROLE_FALL = 2'd3
    } role_t;

    typedef logic [2:0] phase_t;

    typedef struct packed {
        role_t r;
        role_t g;
        role_t b;
    } phase_roles_t;

    localparam phase_t PHASE_0    = 3'd0;
    localparam phase_t PHASE_LAST = 3'd5;

    // One entry per colour-wheel phase; each phase hands one channel from flat to ramping.
    localparam phase_roles_t c_ROLE_TABLE [0:5] = '{
        '{r: ROLE_HIGH, g: ROLE_RISE, b: ROLE_LOW },
        '{r: ROLE_FALL, g: ROLE_HIGH, b: ROLE_LOW },
        '{r: ROLE_LOW,  g: ROLE_HIGH, b: ROLE_RISE},
        '{r: ROLE_LOW,  g: ROLE_FALL, b: ROLE_HIGH},
        '{r: ROLE_RISE, g: ROLE_LOW,  b: ROLE_HIGH},
        '{r: ROLE_HIGH, g: ROLE_LOW,  b: ROLE_FALL}
    };

    function automatic phase_roles_t phase_roles(input phase_t phase);
        if (phase > PHASE_LAST) begin
            return c_ROLE_TABLE[0];
        end
        return c_ROLE_TABLE[int'(phase)];
    endfunction

endpackage

// File: rtl/hsv_pwm_sequencer_duty_ramp.sv
// Maps a channel role and the current fade step to a PWM duty value.
// Purely combinational; no flow control.
module duty_ramp
    import hsv_pwm_pkg::*;
#(
    parameter int c_PWM_INTERVAL    = 1200,
    parameter int c_STEPS_PER_PHASE = 200
) (
    input  role_t                                                          i_role,
    input  logic [((c_STEPS_PER_PHASE > 1) ? $clog2(c_STEPS_PER_PHASE) : 1)-1:0] i_step,
    output logic [$clog2(c_PWM_INTERVAL)-1:0]                              o_duty
);

    localparam int DW        = $clog2(c_PWM_INTERVAL);
    localparam int DUTY_MAX  = c_PWM_INTERVAL - 1;
    localparam int DUTY_STEP = c_PWM_INTERVAL / c_STEPS_PER_PHASE;
    localparam int RAMP_TOP  = c_STEPS_PER_PHASE * DUTY_STEP;
    // Product width covers both the largest ramp and the saturation limit, so the compare is exact.
    localparam int PRODW     = $clog2(((RAMP_TOP > DUTY_MAX) ? RAMP_TOP : DUTY_MAX) + 1);

    localparam logic [PRODW-1:0] DUTY_MAX_P  = PRODW'(DUTY_MAX);
    localparam logic [PRODW-1:0] DUTY_STEP_P = PRODW'(DUTY_STEP);
    localparam logic [DW-1:0]    DUTY_MAX_W  = DW'(DUTY_MAX);

    logic [PRODW-1:0] prod;
    logic [PRODW-1:0] ramp_sat;
    logic [DW-1:0]    ramp;

    assign prod     = PRODW'(i_step) * DUTY_STEP_P;
    assign ramp_sat = (prod > DUTY_MAX_P) ? DUTY_MAX_P : prod;
    assign ramp     = ramp_sat[DW-1:0];

    always_comb begin
        o_duty = '0;
        case (i_role)
            ROLE_LOW:  o_duty = '0;
            ROLE_HIGH: o_duty = DUTY_MAX_W;
            ROLE_RISE: o_duty = ramp;
            ROLE_FALL: o_duty = DUTY_MAX_W - ramp;
            default:   o_duty = '0;
        endcase
    end

endmodule

// File: rtl/hsv_pwm_sequencer.sv
// Walks R/G/B duty values around a six-phase colour wheel, updating only on PWM period boundaries.
// Duty/phase outputs are registered (one cycle after the step edge); no backpressure, i_enable freezes everything.
module hsv_pwm_sequencer
    import hsv_pwm_pkg::*;
#(
    parameter int c_PWM_INTERVAL     = 1200,
    parameter int c_STEPS_PER_PHASE  = 200,
    parameter int c_PERIODS_PER_STEP = 50
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_enable,
    input  logic                              i_restart,
    output logic [$clog2(c_PWM_INTERVAL)-1:0] o_duty_r,
    output logic [$clog2(c_PWM_INTERVAL)-1:0] o_duty_g,
    output logic [$clog2(c_PWM_INTERVAL)-1:0] o_duty_b,
    output logic [2:0]                        o_phase,
    output logic                              o_period_start
);

    localparam int DW   = $clog2(c_PWM_INTERVAL);
    localparam int DIVW = (c_PERIODS_PER_STEP > 1) ? $clog2(c_PERIODS_PER_STEP) : 1;
    localparam int STW  = (c_STEPS_PER_PHASE > 1) ? $clog2(c_STEPS_PER_PHASE) : 1;

    localparam logic [DW-1:0]   PERIOD_LAST = DW'(c_PWM_INTERVAL - 1);
    localparam logic [DIVW-1:0] DIV_LAST    = DIVW'(c_PERIODS_PER_STEP - 1);
    localparam logic [STW-1:0]  STEP_LAST   = STW'(c_STEPS_PER_PHASE - 1);
    localparam logic [DW-1:0]   DUTY_MAX    = DW'(c_PWM_INTERVAL - 1);

    logic [DW-1:0]   period_q, period_d;
    logic [DIVW-1:0] div_q,    div_d;
    logic [STW-1:0]  step_q,   step_d;
    phase_t          phase_q,  phase_d;

    logic [DW-1:0] duty_r_q, duty_r_d;
    logic [DW-1:0] duty_g_q, duty_g_d;
    logic [DW-1:0] duty_b_q, duty_b_d;
    logic          period_start_q, period_start_d;

    logic         period_wrap;
    logic         step_tick;
    logic         step_wrap;
    phase_roles_t roles_d;

    assign period_wrap = i_enable && (period_q == PERIOD_LAST);
    assign step_tick   = period_wrap && (div_q == DIV_LAST);
    assign step_wrap   = step_tick && (step_q == STEP_LAST);

    // Restart wins over everything, including a step_tick in the same cycle.
    always_comb begin
        period_d = period_q;
        div_d    = div_q;
        step_d   = step_q;
        phase_d  = phase_q;
        if (i_restart) begin
            period_d = '0;
            div_d    = '0;
            step_d   = '0;
            phase_d  = PHASE_0;
        end else if (i_enable) begin
            period_d = period_wrap ? '0 : period_q + 1'b1;
            if (period_wrap) begin
                div_d = step_tick ? '0 : div_q + 1'b1;
            end
            if (step_tick) begin
                step_d = step_wrap ? '0 : step_q + 1'b1;
            end
            if (step_wrap) begin
                phase_d = (phase_q == PHASE_LAST) ? PHASE_0 : phase_q + 3'd1;
            end
        end
    end

    // Duties are derived from next-state so the registered outputs track (phase, step) with no lag.
    assign roles_d = phase_roles(phase_d);

    duty_ramp #(
        .c_PWM_INTERVAL   (c_PWM_INTERVAL),
        .c_STEPS_PER_PHASE(c_STEPS_PER_PHASE)
    ) u_ramp_r (
        .i_role(roles_d.r),
        .i_step(step_d),
        .o_duty(duty_r_d)
    );

    duty_ramp #(
        .c_PWM_INTERVAL   (c_PWM_INTERVAL),
        .c_STEPS_PER_PHASE(c_STEPS_PER_PHASE)
    ) u_ramp_g (
        .i_role(roles_d.g),
        .i_step(step_d),
        .o_duty(duty_g_d)
    );

    duty_ramp #(
        .c_PWM_INTERVAL   (c_PWM_INTERVAL),
        .c_STEPS_PER_PHASE(c_STEPS_PER_PHASE)
    ) u_ramp_b (
        .i_role(roles_d.b),
        .i_step(step_d),
        .o_duty(duty_b_d)
    );

    assign period_start_d = !i_restart && i_enable && (period_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q       <= '0;
            div_q          <= '0;
            step_q         <= '0;
            phase_q        <= PHASE_0;
            duty_r_q       <= DUTY_MAX;
            duty_g_q       <= '0;
            duty_b_q       <= '0;
            period_start_q <= 1'b0;
        end else begin
            period_q       <= period_d;
            div_q          <= div_d;
            step_q         <= step_d;
            phase_q        <= phase_d;
            duty_r_q       <= duty_r_d;
            duty_g_q       <= duty_g_d;
            duty_b_q       <= duty_b_d;
            period_start_q <= period_start_d;
        end
    end

    assign o_duty_r       = duty_r_q;
    assign o_duty_g       = duty_g_q;
    assign o_duty_b       = duty_b_q;
    assign o_phase        = phase_q;
    assign o_period_start = period_start_q;

endmodule

// File: doc/hsv_pwm_sequencer.md
Name: hsv_pwm_sequencer

Overview:
Generates the three per-channel PWM duty values (R, G, B) that drive three pwm_loop instances, walking the LED through a continuous six-phase colour wheel. Sits between top level and the pwm_loop instances and owns all fade timing. Duty values only change on PWM-period boundaries, so pwm_loop never sees a mid-period update. A period-start strobe is exported for alignment and debug.

Parameters:
c_PWM_INTERVAL, 1200, clock cycles per PWM period; must match the pwm_loop instances.
c_STEPS_PER_PHASE, 200, duty steps per colour phase.
c_PERIODS_PER_STEP, 50, PWM periods per duty step. Default gives 1 s per phase at 12 MHz.
c_DUTY_MAX (derived), c_PWM_INTERVAL-1, full-on duty value.
c_DUTY_STEP (derived), c_PWM_INTERVAL/c_STEPS_PER_PHASE (integer division), duty increment per step.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  1 = sequencing runs; 0 = all counters and outputs hold
i_restart  in  1  synchronous one-cycle pulse; returns to phase 0, step 0
o_duty_r  out  $clog2(c_PWM_INTERVAL)  red duty value, to pwm_loop l_pwm_value
o_duty_g  out  $clog2(c_PWM_INTERVAL)  green duty value
o_duty_b  out  $clog2(c_PWM_INTERVAL)  blue duty value
o_phase  out  3  current phase, 0..5
o_period_start  out  1  one-cycle pulse in the cycle the internal period counter is 0

Behaviour:
- Reset (async, rst_n=0):
  - period_count=0, div_count=0, step=0, phase=0.
  - o_duty_r=c_DUTY_MAX, o_duty_g=0, o_duty_b=0, o_phase=0, o_period_start=0.
- Counters:
  - period_count runs 0..c_PWM_INTERVAL-1 and wraps.
  - div_count advances when period_count wraps; range 0..c_PERIODS_PER_STEP-1.
  - step advances when div_count wraps; range 0..c_STEPS_PER_PHASE-1.
  - phase advances when step wraps; 5 wraps to 0.
  - All counters advance only while i_enable=1.
- step_tick = i_enable && period_count==c_PWM_INTERVAL-1 && div_count==c_PERIODS_PER_STEP-1.
- Phase role table (R,G,B):
  - 0 = HIGH,RISE,LOW
  - 1 = FALL,HIGH,LOW
  - 2 = LOW,HIGH,RISE
  - 3 = LOW,FALL,HIGH
  - 4 = RISE,LOW,HIGH
  - 5 = HIGH,LOW,FALL
- Duty per role, with ramp = min(step*c_DUTY_STEP, c_DUTY_MAX):
  - LOW = 0
  - HIGH = c_DUTY_MAX
  - RISE = ramp
  - FALL = c_DUTY_MAX - ramp
- Output timing:
  - Outputs are registered: computed from next-state (phase, step), so they always equal f(current phase, step) with no combinational path to ports.
  - Duty outputs change only on the edge where step_tick=1 or i_restart=1.
- o_period_start: registered; high exactly in cycles where period_count==0 and i_enable=1.
- Arithmetic: compute step*c_DUTY_STEP at a width able to hold c_STEPS_PER_PHASE*c_DUTY_STEP without overflow, saturate to c_DUTY_MAX, then truncate to the output width.
- i_restart=1 (any i_enable value):
  - next cycle all counters and outputs equal reset values.
  - restart has priority over step_tick and enable.
- i_enable=0 mid-period: counters freeze; resuming continues from the frozen count with no skipped or repeated step.
- Reset asserted mid-fade: immediate return to reset values; no partial update after release.
- Boundaries:
  - The last step of a RISE yields (c_STEPS_PER_PHASE-1)*c_DUTY_STEP; the next phase's HIGH yields c_DUTY_MAX (no saturation error).
  - The phase 5 to 0 wrap is seamless: R stays c_DUTY_MAX, B goes to 0.

Decomposition:
- Package hsv_pwm_pkg holds:
  - typedef enum role_t {ROLE_LOW, ROLE_HIGH, ROLE_RISE, ROLE_FALL};
  - phase_t (3-bit);
  - constant role table and function phase_roles(phase_t), returning three role_t values.
- Sub-module duty_ramp (role, step -> duty; purely combinational, parameterised by c_PWM_INTERVAL and c_STEPS_PER_PHASE), instantiated 3 times.
- Counters, phase FSM and output registers stay in hsv_pwm_sequencer.

Test Plan:
Bench parameters: c_PWM_INTERVAL=12, c_STEPS_PER_PHASE=4, c_PERIODS_PER_STEP=2, giving c_DUTY_STEP=3, c_DUTY_MAX=11, step every 24 cycles, phase every 96 cycles.
1. Reset, then enable held 1 for 96 cycles -> (R,G,B) = (11,0,0),(11,3,0),(11,6,0),(11,9,0), each held 24 cycles; at cycle 96, (11,11,0) with o_phase=1.
2. Run 576 cycles -> o_phase sequence 0..5 then 0; at cycle 576, outputs (11,0,0); B during phase 5 = 11,8,5,2.
3. o_period_start -> pulses every 12 cycles while enabled; never asserted while i_enable=0.
4. Drop i_enable at cycle 30 for 100 cycles, then resume -> next duty change lands at cycle 148 (24-cycle step timing preserved); G steps 3->6.
5. i_restart in phase 3, step 2, together with a coincident step_tick -> next cycle outputs (11,0,0), o_phase=0, no step applied.
6. rst_n pulsed low asynchronously mid-cycle during phase 4 -> outputs (11,0,0) immediately, before the next clock edge; counting restarts from 0 after release.
